tans_hf_recoder: RTL
====================

# tans_hf_recoder

Inverse of the Huffman→tANS recoder: takes a tANS final state plus the renormalisation bit chunks, supplied newest first, and emits the original Huffman bitstream serially in forward order. It sits on the decode side of the recoder pair. It drives a pull handshake toward the chunk source, which reads the encoder's output back in reverse. The alphabet, Huffman code and tANS table are fixed to match the encoder side: L=8, 4-bit state 8..15.

## Interface
Parameters:
- NSYM_W, 8, width of the symbol-count input

Ports:
- PHI  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- I_F  in  1  start strobe; loads init_state and n_sym; honoured only while busy=0
- init_state  in  4  encoder final state; bit 3 forced to 1 on load
- n_sym  in  NSYM_W  number of symbols to decode
- BTR  out  2  bits requested for the current fetch (1 or 2); 0 when bits_rdy=0
- bits_rdy  out  1  decoder waiting for a chunk
- bits_vld  in  1  chunk present on bits_in
- bits_in  in  2  chunk, right-aligned; only bits [BTR-1:0] used
- o_stream  out  1  Huffman output bit
- o_vld  out  1  o_stream valid this cycle
- busy  out  1  decode in progress
- done  out  1  one-cycle pulse after the last fetch
- final_state  out  4  state register after the last fetch; equals the encoder's start state

## Operation
- Symbols and Huffman codes: A=0, B=10, C=11. Frequencies: A=4, B=2, C=2.
- Slot map for i = state-8:
  - i 0..3 → A, x_s = 4+i, nb = 1
  - i 4..5 → B, x_s = 2+(i-4), nb = 2
  - i 6..7 → C, x_s = 2+(i-6), nb = 2
- Next state = (x_s << nb) | bits_in[nb-1:0]. The result is always within 8..15, so no wrap is possible.
- FSM states: IDLE, EMIT, FETCH, DONE.
  - IDLE: if I_F=1, load state←init_state|8 and cnt←n_sym. If n_sym=0 go to DONE, otherwise go to EMIT.
  - EMIT: drive o_vld=1 and o_stream = Huffman bit k of the current symbol, MSB first.
    - A uses 1 cycle. B and C use 2 cycles.
    - After the last bit, go to FETCH.
  - FETCH: bits_rdy=1 and BTR=nb; hold until bits_vld=1.
    - On the handshake edge: state←next, cnt←cnt-1.
    - If cnt was 1, go to DONE; otherwise go to EMIT.
  - DONE: done=1 for one cycle, then IDLE. final_state holds until the next I_F.
- busy = 1 in EMIT and FETCH; 0 in IDLE and DONE.
- I_F is ignored while busy=1. I_F is accepted in IDLE and in DONE; in DONE it starts a new run and the done pulse still asserts.
- The state register is not exposed. final_state updates only on entry to DONE.
- bits_vld outside FETCH is ignored; no chunk is consumed.

## Timing
- Reset values: state regs 0, FSM=IDLE, cnt=0. All outputs are 0, including BTR, bits_rdy, o_vld, o_stream, busy, done and final_state.
- RST asserted mid-run aborts immediately (async). No done pulse is produced and outputs read 0 until the next I_F after release.
- The first o_vld appears in the cycle after the I_F edge.
- FETCH presents BTR/bits_rdy combinationally from the FSM state in the first FETCH cycle. With bits_vld tied high, each FETCH lasts one cycle.
- Zero-wait throughput: A takes 2 cycles per symbol; B and C take 3.
- done asserts in the cycle after the final handshake edge. final_state is valid in the same cycle.
- n_sym=0: done asserts in the cycle after I_F, with final_state=init_state|8 and no o_vld or bits_rdy.
- Back-pressure: o_vld has no ready. Downstream must always accept.

## Test plan
- Reset: assert RST mid-EMIT → all outputs 0 in the same cycle. Release RST with I_F=0 → IDLE, outputs stay 0.
- Single A: init_state=8, n_sym=1, bits_vld=1, bits_in=2'b01.
  - o_stream 0 in cycle 1.
  - BTR=1 in cycle 2.
  - done in cycle 3 with final_state=9.
- Two symbols: init_state=13, n_sym=2, bits_in 2'b10 then 2'b01, bits_vld=1.
  - o_stream 1,0 (cycles 1-2), BTR=2 (cycle 3), o_stream 1,1 (cycles 4-5), BTR=2 (cycle 6).
  - done in cycle 7 with final_state=9.
- Stall: repeat the two-symbol case with bits_vld low for 3 cycles in each FETCH.
  - BTR and bits_rdy held, no o_vld.
  - Same bit sequence and final_state; done in cycle 13.
- n_sym=0, init_state=5 → done in cycle 1, final_state=13, no o_vld or bits_rdy.
- I_F pulsed while busy → ignored, the run completes unchanged. I_F in the DONE cycle → new run starts, o_vld in the next cycle.

Source files
------------

// File: rtl/tans_hf_recoder.sv
// tANS -> Huffman decode-side recoder: walks the tANS state backwards from the
// encoder's final state, pulling renormalisation chunks and emitting Huffman bits.
module tans_hf_recoder #(
  parameter int NSYM_W = 8
) (
  input  logic              PHI,
  input  logic              RST,
  input  logic              I_F,
  input  logic [3:0]        init_state,
  input  logic [NSYM_W-1:0] n_sym,
  output logic [1:0]        BTR,
  output logic              bits_rdy,
  input  logic              bits_vld,
  input  logic [1:0]        bits_in,
  output logic              o_stream,
  output logic              o_vld,
  output logic              busy,
  output logic              done,
  output logic [3:0]        final_state
);

  typedef enum logic [1:0] {IDLE, EMIT, FETCH, DONE} fsm_t;

  fsm_t              fsm;
  logic [3:0]        state;
  logic [NSYM_W-1:0] cnt;
  logic              bit_idx;
  logic [3:0]        nxt;
  logic [3:0]        ld;

  // state[2]=0 selects A (slot i=state[1:0], x_s=4+i); state[2]=1 selects B/C with
  // x_s=2+state[0]. Shifting x_s left by nb and appending the chunk lands in 8..15.
  function automatic logic [3:0] next_state_f(input logic [3:0] s, input logic [1:0] b);
    return s[2] ? {1'b1, s[0], b} : {1'b1, s[1:0], b[0]};
  endfunction

  // Code length equals renormalisation width: A is 1 bit, B/C are 2 bits.
  function automatic logic [1:0] nb_f(input logic [3:0] s);
    return s[2] ? 2'd2 : 2'd1;
  endfunction

  assign nxt = next_state_f(state, bits_in);
  assign ld  = init_state | 4'b1000;

  always_ff @(posedge PHI or posedge RST) begin
    if (RST) begin
      fsm         <= IDLE;
      state       <= '0;
      cnt         <= '0;
      bit_idx     <= 1'b0;
      BTR         <= '0;
      bits_rdy    <= 1'b0;
      o_stream    <= 1'b0;
      o_vld       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      final_state <= '0;
    end else begin
      done <= 1'b0;
      case (fsm)
        IDLE, DONE: begin
          fsm      <= IDLE;
          busy     <= 1'b0;
          o_vld    <= 1'b0;
          o_stream <= 1'b0;
          BTR      <= '0;
          bits_rdy <= 1'b0;
          if (I_F) begin
            state   <= ld;
            cnt     <= n_sym;
            bit_idx <= 1'b0;
            if (n_sym == '0) begin
              fsm         <= DONE;
              done        <= 1'b1;
              final_state <= ld;
            end else begin
              fsm      <= EMIT;
              busy     <= 1'b1;
              o_vld    <= 1'b1;
              o_stream <= ld[2];
            end
          end
        end
        // Huffman bits: first bit is state[2] (A=0, B/C=1), second is state[1] (B=0, C=1).
        EMIT: begin
          if (state[2] && !bit_idx) begin
            bit_idx  <= 1'b1;
            o_stream <= state[1];
          end else begin
            fsm      <= FETCH;
            o_vld    <= 1'b0;
            o_stream <= 1'b0;
            bits_rdy <= 1'b1;
            BTR      <= nb_f(state);
          end
        end
        FETCH: begin
          if (bits_vld) begin
            state    <= nxt;
            cnt      <= cnt - NSYM_W'(1);
            bits_rdy <= 1'b0;
            BTR      <= '0;
            bit_idx  <= 1'b0;
            if (cnt == NSYM_W'(1)) begin
              fsm         <= DONE;
              done        <= 1'b1;
              busy        <= 1'b0;
              final_state <= nxt;
            end else begin
              fsm      <= EMIT;
              o_vld    <= 1'b1;
              o_stream <= nxt[2];
            end
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule
